// File: rtl/seg7_scan_if.sv
// rtl/seg7_scan_if.sv - snooped seven-segment bus plus decoded readback signals
interface seg7_scan_if #(
    parameter int DIGITS = 4
);
    logic [6:0]          seg_in;
    logic [DIGITS-1:0]   an_in;
    logic [4*DIGITS-1:0] digits_out;
    logic [DIGITS-1:0]   digit_valid;
    logic [DIGITS-1:0]   pat_err;
    logic                upd;
    logic                frame_done;

    modport master (
        output seg_in, an_in,
        input  digits_out, digit_valid, pat_err, upd, frame_done
    );

    modport slave (
        input  seg_in, an_in,
        output digits_out, digit_valid, pat_err, upd, frame_done
    );
endinterface

// File: rtl/seg7_scan_monitor.sv
// rtl/seg7_scan_monitor.sv - decodes a multiplexed seven-segment bus back to hex digits
module seg7_scan_monitor #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);
    localparam int W  = 7 + DIGITS;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    typedef enum logic [1:0] {S_WAIT, S_COUNT, S_HELD} state_t;

    state_t              state;
    logic [W-1:0]        sync1;
    logic [W-1:0]        sync2;
    logic [CW-1:0]       cnt;
    logic [DIGITS-1:0]   seen;
    logic [4*DIGITS-1:0] digits_r;
    logic [DIGITS-1:0]   valid_r;
    logic [DIGITS-1:0]   err_r;
    logic                upd_r;
    logic                frame_r;

    logic                changed;
    logic                onehot;
    logic [6:0]          cur_seg;
    logic [DIGITS-1:0]   cur_an;
    logic [4:0]          dec;
    logic [CW-1:0]       cnt_next;
    logic [DIGITS-1:0]   seen_next;

    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F: decode = {1'b1, 4'h0};
            7'h06: decode = {1'b1, 4'h1};
            7'h5B: decode = {1'b1, 4'h2};
            7'h4F: decode = {1'b1, 4'h3};
            7'h66: decode = {1'b1, 4'h4};
            7'h6D: decode = {1'b1, 4'h5};
            7'h7D: decode = {1'b1, 4'h6};
            7'h07: decode = {1'b1, 4'h7};
            7'h7F: decode = {1'b1, 4'h8};
            7'h6F: decode = {1'b1, 4'h9};
            7'h77: decode = {1'b1, 4'hA};
            7'h7C: decode = {1'b1, 4'hB};
            7'h39: decode = {1'b1, 4'hC};
            7'h5E: decode = {1'b1, 4'hD};
            7'h79: decode = {1'b1, 4'hE};
            7'h71: decode = {1'b1, 4'hF};
            default: decode = 5'b0_0000;
        endcase
    endfunction

    // Stability is judged between the value entering stage 2 and the value it holds,
    // so the counter reads 1 on the edge right after stage 2 settles.
    always_comb begin
        cur_seg   = sync1[6:0];
        cur_an    = sync1[W-1:7];
        changed   = (sync1 != sync2);
        onehot    = $onehot(cur_an);
        dec       = decode(cur_seg);
        cnt_next  = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        seen_next = seen | cur_an;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_WAIT;
            sync1    <= '0;
            sync2    <= '0;
            cnt      <= '0;
            seen     <= '0;
            digits_r <= '0;
            valid_r  <= '0;
            err_r    <= '0;
            upd_r    <= 1'b0;
            frame_r  <= 1'b0;
        end else begin
            sync1   <= {bus.an_in, bus.seg_in};
            sync2   <= sync1;
            upd_r   <= 1'b0;
            frame_r <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (!changed && onehot) begin
                        state <= S_COUNT;
                        cnt   <= CW'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                S_COUNT: begin
                    if (changed) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_next;
                        if (cnt_next == CNT_MAX) begin
                            state <= S_HELD;
                            upd_r <= 1'b1;
                            for (int i = 0; i < DIGITS; i++) begin
                                if (cur_an[i]) begin
                                    if (dec[4])
                                        digits_r[4*i +: 4] <= dec[3:0];
                                    valid_r[i] <= dec[4];
                                    err_r[i]   <= !dec[4] && (cur_seg != 7'h00);
                                end
                            end
                            if (&seen_next) begin
                                frame_r <= 1'b1;
                                seen    <= '0;
                            end else begin
                                seen <= seen_next;
                            end
                        end
                    end
                end
                S_HELD: begin
                    if (changed) begin
                        state <= S_WAIT;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= S_WAIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.digits_out  = digits_r;
    assign bus.digit_valid = valid_r;
    assign bus.pat_err     = err_r;
    assign bus.upd         = upd_r;
    assign bus.frame_done  = frame_r;
endmodule
